// File: rtl/pc_fetch_gen_pkg.sv
// Shared types and constants for the PC / fetch-address generator.
// The HALT state exists only when PC_ALIGN_CHECK_EN is defined.
package pc_pkg;

    localparam int unsigned PC_XLEN = 32;
    localparam logic [PC_XLEN-1:0] PC_RESET_VEC = 32'h0000_0000;
    localparam logic [PC_XLEN-1:0] PC_INC       = 32'd4;

    typedef enum logic [1:0] {
        BOOT,
        FETCH,
        HOLD
`ifdef PC_ALIGN_CHECK_EN
        ,
        HALT
`endif
    } pc_state_t;

endpackage

// File: rtl/pc_fetch_gen_if.sv
// Instruction-memory fetch request channel (valid/ready, address).
interface pc_fetch_gen_if #(
    parameter int unsigned XLEN = 32
);
    logic            imem_req_valid;
    logic            imem_req_ready;
    logic [XLEN-1:0] imem_addr;

    modport master (output imem_req_valid, output imem_addr, input imem_req_ready);
    modport slave  (input imem_req_valid, input imem_addr, output imem_req_ready);
endinterface

// File: rtl/pc_fetch_gen_nbitadder.sv
// 32-bit ripple-carry adder; the carry-out is dropped so the sum wraps modulo 2^32.
module nbitadder
    import pc_pkg::*;
(
    input  logic [PC_XLEN-1:0] a,
    input  logic [PC_XLEN-1:0] b,
    output logic [PC_XLEN-1:0] s
);

    logic carry;

    // Carry ripples bit by bit through a procedural variable.
    always_comb begin
        carry = 1'b0;
        s     = '0;
        for (int i = 0; i < int'(PC_XLEN); i++) begin
            s[i]  = a[i] ^ b[i] ^ carry;
            carry = (a[i] & b[i]) | (carry & (a[i] ^ b[i]));
        end
    end

endmodule

// File: rtl/pc_fetch_gen.sv
// PC register, fetch FSM and pending-redirect holding for instruction fetch.
// Optional misaligned-redirect trap: define PC_ALIGN_CHECK_EN.
module pc_fetch_gen
    import pc_pkg::*;
#(
    parameter int unsigned     XLEN      = PC_XLEN,
    parameter logic [XLEN-1:0] RESET_VEC = PC_RESET_VEC,
    parameter logic [XLEN-1:0] INC       = PC_INC
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  stall,
    input  logic                  redir_valid,
    input  logic [XLEN-1:0]       redir_target,
    pc_fetch_gen_if.master        imem,
    output logic [XLEN-1:0]       pc_plus_inc,
    output logic                  align_fault
);

    pc_state_t       state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] pend_tgt_q, pend_tgt_d;
    logic            pend_vld_q, pend_vld_d;
    logic            valid_q, valid_d;
    logic [XLEN-1:0] tgt_c;
    logic [XLEN-1:0] sum_c;

    nbitadder u_add (
        .a (pc_q),
        .b (INC),
        .s (sum_c)
    );

`ifdef PC_ALIGN_CHECK_EN
    logic fault_q, fault_d;
    logic bad_c;
    assign tgt_c = redir_target;
    assign bad_c = redir_valid && (redir_target[1:0] != 2'b00);
`else
    logic unused_tgt_lsb;
    assign tgt_c          = {redir_target[XLEN-1:2], 2'b00};
    assign unused_tgt_lsb = ^redir_target[1:0];
`endif

    // Next-state, next-PC and pending-redirect selection.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        pend_vld_d = pend_vld_q;
        pend_tgt_d = pend_tgt_q;
`ifdef PC_ALIGN_CHECK_EN
        fault_d    = 1'b0;
`endif
        case (state_q)
            BOOT: begin
                state_d = FETCH;
                if (redir_valid) pc_d = tgt_c;
            end
            FETCH: begin
                if (imem.imem_req_ready) begin
                    if (redir_valid)     pc_d = tgt_c;
                    else if (pend_vld_q) pc_d = pend_tgt_q;
                    else                 pc_d = sum_c;
                    pend_vld_d = 1'b0;
                    state_d    = stall ? HOLD : FETCH;
                end else if (redir_valid) begin
                    // Address must stay stable while stalled by memory; remember the redirect.
                    pend_tgt_d = tgt_c;
                    pend_vld_d = 1'b1;
                end
            end
            HOLD: begin
                if (redir_valid) begin
                    pc_d       = tgt_c;
                    pend_vld_d = 1'b0;
                end else if (pend_vld_q) begin
                    pc_d       = pend_tgt_q;
                    pend_vld_d = 1'b0;
                end
                if (!stall) state_d = FETCH;
            end
            default: state_d = state_q;
        endcase
`ifdef PC_ALIGN_CHECK_EN
        // A misaligned redirect is dropped and traps the fetch unit until reset.
        if (bad_c && (state_q != HALT)) begin
            state_d    = HALT;
            pc_d       = pc_q;
            pend_vld_d = 1'b0;
            fault_d    = 1'b1;
        end
`endif
    end

    assign valid_d = (state_d == FETCH);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= BOOT;
            pc_q       <= RESET_VEC;
            pend_tgt_q <= '0;
            pend_vld_q <= 1'b0;
            valid_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            pend_tgt_q <= pend_tgt_d;
            pend_vld_q <= pend_vld_d;
            valid_q    <= valid_d;
        end
    end

`ifdef PC_ALIGN_CHECK_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) fault_q <= 1'b0;
        else        fault_q <= fault_d;
    end
    assign align_fault = fault_q;
`else
    assign align_fault = 1'b0;
`endif

    assign imem.imem_req_valid = valid_q;
    assign imem.imem_addr      = pc_q;
    assign pc_plus_inc         = sum_c;

endmodule
